sdram_arb: RTL and testbench

Three-requester Wishbone arbiter that shares the single SDRAM controller port between video DMA, sound DMA and the CPU. It sits in the `wb_clk` domain between the requesters and the SDRAM controller's `wb_*` slave port. It grants one master at a time and holds the grant for the whole cycle, including incrementing bursts. It inserts one dead cycle between grants, so every new request reaches the controller as a fresh `stb&cyc` rising edge with `ack` already low. Fixed priority applies, with a starvation override for the CPU.

---
 rtl/sdram_arb_if.sv | 69 ++++++
 rtl/sdram_arb.sv | 134 +++++++++++++
 tb/tb_sdram_arb.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_if.sv
// Bundle of the three Wishbone requester links, the controller link and arbiter status.
// Latency: none (wires only).
// Backpressure: Wishbone stb/ack; a master waits for its ack, and a master without the grant never sees one.
interface sdram_arb_if;
  // video DMA master
  logic        vid_cyc;
  logic        vid_stb;
  logic        vid_we;
  logic [23:0] vid_adr;
  logic [3:0]  vid_sel;
  logic [2:0]  vid_cti;
  logic [31:0] vid_dat_i;
  logic        vid_ack;
  // sound DMA master
  logic        snd_cyc;
  logic        snd_stb;
  logic        snd_we;
  logic [23:0] snd_adr;
  logic [3:0]  snd_sel;
  logic [2:0]  snd_cti;
  logic [31:0] snd_dat_i;
  logic        snd_ack;
  // CPU master
  logic        cpu_cyc;
  logic        cpu_stb;
  logic        cpu_we;
  logic [23:0] cpu_adr;
  logic [3:0]  cpu_sel;
  logic [2:0]  cpu_cti;
  logic [31:0] cpu_dat_i;
  logic        cpu_ack;
  // read data broadcast to every master
  logic [31:0] wb_dat_o;
  // SDRAM controller slave port
  logic        s_cyc;
  logic        s_stb;
  logic        s_we;
  logic [23:0] s_adr;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic [31:0] s_dat_o;
  logic [31:0] s_dat_i;
  logic        s_ack;
  // status
  logic [2:0]  grant;
  logic        busy;

  // Requesters and controller side: drives requests and slave responses.
  modport master (
    output vid_cyc, vid_stb, vid_we, vid_adr, vid_sel, vid_cti, vid_dat_i,
    output snd_cyc, snd_stb, snd_we, snd_adr, snd_sel, snd_cti, snd_dat_i,
    output cpu_cyc, cpu_stb, cpu_we, cpu_adr, cpu_sel, cpu_cti, cpu_dat_i,
    output s_dat_i, s_ack,
    input  vid_ack, snd_ack, cpu_ack, wb_dat_o,
    input  s_cyc, s_stb, s_we, s_adr, s_sel, s_cti, s_dat_o,
    input  grant, busy
  );

  // Arbiter side.
  modport slave (
    input  vid_cyc, vid_stb, vid_we, vid_adr, vid_sel, vid_cti, vid_dat_i,
    input  snd_cyc, snd_stb, snd_we, snd_adr, snd_sel, snd_cti, snd_dat_i,
    input  cpu_cyc, cpu_stb, cpu_we, cpu_adr, cpu_sel, cpu_cti, cpu_dat_i,
    input  s_dat_i, s_ack,
    output vid_ack, snd_ack, cpu_ack, wb_dat_o,
    output s_cyc, s_stb, s_we, s_adr, s_sel, s_cti, s_dat_o,
    output grant, busy
  );
endinterface

// File: rtl/sdram_arb.sv
// Three-way Wishbone arbiter (vid > snd > cpu, CPU starvation override) onto the SDRAM controller port.
// Latency: one cycle request-to-grant from IDLE; data path and ack are combinational once granted.
// Backpressure: grant held for the whole cyc; one dead GAP cycle between grants; losers just wait.
module sdram_arb #(
  parameter int STARVE_LIMIT = 64
) (
  input  logic         wb_clk,
  input  logic         wb_rst_n,
  sdram_arb_if.slave   bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    req;
  logic [2:0]    cyc_v;
  logic [CW-1:0] starve_cnt;
  logic          starve_hit;

  // bit order matches grant: 0 vid, 1 snd, 2 cpu
  assign req   = {bus.cpu_cyc & bus.cpu_stb, bus.snd_cyc & bus.snd_stb, bus.vid_cyc & bus.vid_stb};
  assign cyc_v = {bus.cpu_cyc, bus.snd_cyc, bus.vid_cyc};

  // Uses the pre-edge count, so a count reaching the limit on a grant edge only matters next time.
  assign starve_hit = (starve_cnt == LIMIT);

  // State and grant register.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Arbitration and release: grant in IDLE, hold while granted cyc is high, one dead cycle after.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          if (starve_hit && req[2]) grant_d = 3'b100;
          else if (req[0])          grant_d = 3'b001;
          else if (req[1])          grant_d = 3'b010;
          else                      grant_d = 3'b100;
        end
      end
      BUSY: begin
        if (!(|(grant_q & cyc_v))) begin
          state_d = GAP;
          grant_d = 3'b000;
        end
      end
      GAP: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
    endcase
  end

  // CPU wait counter: counts ungranted pending cycles, saturates, clears on grant or withdrawal.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      starve_cnt <= '0;
    end else if (!req[2] || grant_q[2] || grant_d[2]) begin
      starve_cnt <= '0;
    end else if (!starve_hit) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // Controller-side mux keyed off the registered grant; everything is zero with no grant.
  always_comb begin
    bus.s_cyc   = 1'b0;
    bus.s_stb   = 1'b0;
    bus.s_we    = 1'b0;
    bus.s_adr   = 24'h0;
    bus.s_sel   = 4'h0;
    bus.s_cti   = 3'b000;
    bus.s_dat_o = 32'h0;
    case (grant_q)
      3'b001: begin
        bus.s_cyc   = bus.vid_cyc;
        bus.s_stb   = bus.vid_stb;
        bus.s_we    = bus.vid_we;
        bus.s_adr   = bus.vid_adr;
        bus.s_sel   = bus.vid_sel;
        bus.s_cti   = bus.vid_cti;
        bus.s_dat_o = bus.vid_dat_i;
      end
      3'b010: begin
        bus.s_cyc   = bus.snd_cyc;
        bus.s_stb   = bus.snd_stb;
        bus.s_we    = bus.snd_we;
        bus.s_adr   = bus.snd_adr;
        bus.s_sel   = bus.snd_sel;
        bus.s_cti   = bus.snd_cti;
        bus.s_dat_o = bus.snd_dat_i;
      end
      3'b100: begin
        bus.s_cyc   = bus.cpu_cyc;
        bus.s_stb   = bus.cpu_stb;
        bus.s_we    = bus.cpu_we;
        bus.s_adr   = bus.cpu_adr;
        bus.s_sel   = bus.cpu_sel;
        bus.s_cti   = bus.cpu_cti;
        bus.s_dat_o = bus.cpu_dat_i;
      end
      default: ;
    endcase
  end

  // Ack goes only to the granted master; a stray ack with no grant is dropped.
  assign bus.vid_ack  = grant_q[0] & bus.s_ack;
  assign bus.snd_ack  = grant_q[1] & bus.s_ack;
  assign bus.cpu_ack  = grant_q[2] & bus.s_ack;
  assign bus.wb_dat_o = bus.s_dat_i;

  assign bus.grant = grant_q;
  assign bus.busy  = (state_q == BUSY);

endmodule

// File: tb/tb_sdram_arb.sv
// Self-checking bench for sdram_arb: directed scenarios plus a grant-order scoreboard.
// Latency: checks sampled 1 time unit after each rising edge; the monitor samples 2 units after.
// Backpressure: the bench plays the SDRAM slave and drives s_ack directly.
module tb_sdram_arb;

  logic wb_clk;
  logic wb_rst_n;

  sdram_arb_if bus ();

  sdram_arb #(.STARVE_LIMIT(4)) u_dut (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .bus      (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] exp_grant_q[$];

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge wb_clk);
    #1;
  endtask

  task automatic clear_masters();
    bus.vid_cyc = 0; bus.vid_stb = 0; bus.vid_we = 0; bus.vid_adr = '0; bus.vid_sel = '0; bus.vid_cti = '0; bus.vid_dat_i = '0;
    bus.snd_cyc = 0; bus.snd_stb = 0; bus.snd_we = 0; bus.snd_adr = '0; bus.snd_sel = '0; bus.snd_cti = '0; bus.snd_dat_i = '0;
    bus.cpu_cyc = 0; bus.cpu_stb = 0; bus.cpu_we = 0; bus.cpu_adr = '0; bus.cpu_sel = '0; bus.cpu_cti = '0; bus.cpu_dat_i = '0;
    bus.s_ack = 0; bus.s_dat_i = '0;
  endtask

  // Scoreboard: every fresh grant (000 -> non-zero) must match the next expected winner.
  initial begin
    logic [2:0] prev;
    prev = 3'b000;
    forever begin
      @(posedge wb_clk);
      #2;
      if (bus.grant != 3'b000 && prev == 3'b000) begin
        if (exp_grant_q.size() == 0) chk("sb_unexpected_grant", 32'(bus.grant), 32'h0);
        else                         chk("sb_grant_order", 32'(bus.grant), 32'(exp_grant_q.pop_front()));
      end
      prev = bus.grant;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_masters();
    wb_rst_n = 1'b0;
    #2;
    // reset state, before any clock edge
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_busy",  32'(bus.busy),  32'h0);
    chk("rst_s_cyc", 32'(bus.s_cyc), 32'h0);
    chk("rst_acks",  32'({bus.vid_ack, bus.snd_ack, bus.cpu_ack}), 32'h0);
    chk("rst_cnt",   32'(u_dut.starve_cnt), 32'h0);
    #6 wb_rst_n = 1'b1;
    step(1);

    // ---- single CPU read ----
    bus.cpu_cyc = 1; bus.cpu_stb = 1; bus.cpu_adr = 24'h123456; bus.cpu_sel = 4'hF;
    exp_grant_q.push_back(3'b100);
    #1 chk("t1_pre_s_cyc", 32'(bus.s_cyc), 32'h0);
    chk("t1_pre_s_adr", 32'(bus.s_adr), 32'h0);
    step(1);
    chk("t1_grant", 32'(bus.grant), 32'h4);
    chk("t1_s_cyc", 32'(bus.s_cyc), 32'h1);
    chk("t1_s_adr", 32'(bus.s_adr), 32'h123456);
    chk("t1_busy",  32'(bus.busy),  32'h1);
    step(3);
    bus.s_ack = 1; bus.s_dat_i = 32'hCAFE_0001;
    #1;
    chk("t1_cpu_ack", 32'(bus.cpu_ack), 32'h1);
    chk("t1_oth_ack", 32'({bus.vid_ack, bus.snd_ack}), 32'h0);
    chk("t1_dat",     bus.wb_dat_o, 32'hCAFE_0001);
    bus.s_ack = 0; bus.cpu_cyc = 0; bus.cpu_stb = 0;
    step(1);
    chk("t1_rel_grant", 32'(bus.grant), 32'h0);
    chk("t1_rel_busy",  32'(bus.busy),  32'h0);
    bus.cpu_cyc = 1; bus.cpu_stb = 1;
    exp_grant_q.push_back(3'b100);
    step(1);
    chk("t1_gap_grant", 32'(bus.grant), 32'h0);
    chk("t1_gap_s_cyc", 32'(bus.s_cyc), 32'h0);
    step(1);
    chk("t1_regrant", 32'(bus.grant), 32'h4);
    bus.cpu_cyc = 0; bus.cpu_stb = 0;
    step(2);

    // ---- simultaneous vid + cpu ----
    bus.vid_cyc = 1; bus.vid_stb = 1; bus.vid_adr = 24'hABCDEF; bus.vid_sel = 4'hF;
    bus.cpu_cyc = 1; bus.cpu_stb = 1; bus.cpu_adr = 24'h000111;
    exp_grant_q.push_back(3'b001);
    exp_grant_q.push_back(3'b100);
    step(1);
    chk("t2_grant_vid", 32'(bus.grant), 32'h1);
    chk("t2_s_adr",     32'(bus.s_adr), 32'hABCDEF);
    step(1);
    bus.vid_cyc = 0; bus.vid_stb = 0;
    step(1);
    chk("t2_rel", 32'(bus.grant), 32'h0);
    step(1);
    chk("t2_idle", 32'(bus.grant), 32'h0);
    step(1);
    chk("t2_grant_cpu", 32'(bus.grant), 32'h4);
    chk("t2_s_adr_cpu", 32'(bus.s_adr), 32'h000111);
    bus.cpu_cyc = 0; bus.cpu_stb = 0;
    step(2);

    // ---- video burst with sound waiting ----
    bus.vid_cyc = 1; bus.vid_stb = 1; bus.vid_cti = 3'b010; bus.vid_adr = 24'h000400;
    bus.snd_cyc = 1; bus.snd_stb = 1; bus.snd_adr = 24'h000800; bus.snd_sel = 4'hF;
    exp_grant_q.push_back(3'b001);
    exp_grant_q.push_back(3'b010);
    step(1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_hold_pre", 32'(bus.grant), 32'h1);
      step(1);
    end
    for (int i = 0; i < 4; i++) begin
      bus.s_ack = 1; bus.s_dat_i = 32'hB000_0000 + 32'(i);
      #1;
      chk("t3_burst_grant", 32'(bus.grant), 32'h1);
      chk("t3_vid_ack",     32'(bus.vid_ack), 32'h1);
      chk("t3_snd_ack",     32'(bus.snd_ack), 32'h0);
      chk("t3_s_cti",       32'(bus.s_cti), 32'h2);
      chk("t3_dat",         bus.wb_dat_o, 32'hB000_0000 + 32'(i));
      if (i == 3) begin
        bus.s_ack = 0; bus.vid_cyc = 0; bus.vid_stb = 0; bus.vid_cti = 3'b000;
      end
      step(1);
    end
    chk("t3_rel",  32'(bus.grant), 32'h0);
    step(1);
    chk("t3_idle", 32'(bus.grant), 32'h0);
    step(1);
    chk("t3_snd_grant", 32'(bus.grant), 32'h2);
    chk("t3_snd_adr",   32'(bus.s_adr), 32'h000800);
    bus.snd_cyc = 0; bus.snd_stb = 0;
    step(2);

    // ---- CPU starvation, limit 4 ----
    bus.vid_cyc = 1; bus.vid_stb = 1;
    bus.snd_cyc = 1; bus.snd_stb = 1; bus.snd_cti = 3'b010;
    bus.cpu_cyc = 1; bus.cpu_stb = 1;
    exp_grant_q.push_back(3'b001);
    exp_grant_q.push_back(3'b001);
    exp_grant_q.push_back(3'b100);
    exp_grant_q.push_back(3'b010);
    step(1);
    chk("t4_g1", 32'(bus.grant), 32'h1);
    bus.vid_cyc = 0; bus.vid_stb = 0;
    step(1);
    chk("t4_rel1", 32'(bus.grant), 32'h0);
    bus.vid_cyc = 1; bus.vid_stb = 1;
    step(2);
    chk("t4_g2_no_override", 32'(bus.grant), 32'h1);
    chk("t4_cnt_at_limit",   32'(u_dut.starve_cnt), 32'h4);
    bus.vid_cyc = 0; bus.vid_stb = 0;
    step(1);
    bus.vid_cyc = 1; bus.vid_stb = 1;
    step(1);
    chk("t4_idle", 32'(bus.grant), 32'h0);
    step(1);
    chk("t4_override", 32'(bus.grant), 32'h4);
    chk("t4_cnt_clr",  32'(u_dut.starve_cnt), 32'h0);
    bus.cpu_cyc = 0; bus.cpu_stb = 0;
    bus.vid_cyc = 0; bus.vid_stb = 0;
    step(3);

    // ---- async reset mid-burst with sound granted ----
    chk("t5_snd_grant", 32'(bus.grant), 32'h2);
    bus.s_ack = 1; bus.s_dat_i = 32'h5555_AAAA;
    #1 chk("t5_snd_ack", 32'(bus.snd_ack), 32'h1);
    #2 wb_rst_n = 1'b0;
    #1;
    chk("t5_rst_grant",   32'(bus.grant),   32'h0);
    chk("t5_rst_s_cyc",   32'(bus.s_cyc),   32'h0);
    chk("t5_rst_snd_ack", 32'(bus.snd_ack), 32'h0);
    chk("t5_rst_busy",    32'(bus.busy),    32'h0);
    clear_masters();
    #2 wb_rst_n = 1'b1;
    step(2);

    // ---- CPU write aborted without ack, vid pending ----
    bus.cpu_cyc = 1; bus.cpu_stb = 1; bus.cpu_we = 1; bus.cpu_adr = 24'h0F0F0F;
    bus.cpu_sel = 4'h3; bus.cpu_dat_i = 32'hDEAD_BEEF;
    exp_grant_q.push_back(3'b100);
    exp_grant_q.push_back(3'b001);
    step(1);
    chk("t6_grant", 32'(bus.grant),   32'h4);
    chk("t6_s_we",  32'(bus.s_we),    32'h1);
    chk("t6_s_sel", 32'(bus.s_sel),   32'h3);
    chk("t6_s_dat", bus.s_dat_o,      32'hDEAD_BEEF);
    bus.vid_cyc = 1; bus.vid_stb = 1; bus.vid_adr = 24'h000042;
    bus.cpu_cyc = 0; bus.cpu_stb = 0; bus.cpu_we = 0;
    step(1);
    chk("t6_rel_grant", 32'(bus.grant), 32'h0);
    chk("t6_rel_s_cyc", 32'(bus.s_cyc), 32'h0);
    step(1);
    chk("t6_idle", 32'(bus.grant), 32'h0);
    step(1);
    chk("t6_vid_grant", 32'(bus.grant), 32'h1);
    chk("t6_vid_adr",   32'(bus.s_adr), 32'h000042);
    bus.vid_cyc = 0; bus.vid_stb = 0;
    step(3);

    chk("sb_drained", 32'(exp_grant_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
